// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: two-master request/grant/read-return bus plus memory port; master = masters+memory side, slave = arbiter side
interface mem_port_arbiter_if #(parameter int AW = 16, parameter int DW = 16);
  logic          req0, w0, lock0, gnt0, valid0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] dout0;
  logic          req1, w1, lock1, gnt1, valid1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] dout1;
  logic [DW-1:0] rd_data, mem_dout, mem_din;
  logic [AW-1:0] mem_addr;
  logic          mem_w;
  modport master (
    output req0, w0, lock0, addr0, dout0, req1, w1, lock1, addr1, dout1, mem_din,
    input  gnt0, valid0, gnt1, valid1, rd_data, mem_addr, mem_dout, mem_w
  );
  modport slave (
    input  req0, w0, lock0, addr0, dout0, req1, w1, lock1, addr1, dout1, mem_din,
    output gnt0, valid0, gnt1, valid1, rd_data, mem_addr, mem_dout, mem_w
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin two-master arbiter for one memory port with bounded lock, registered mem outputs and tagged read return; ports i_clk, i_rst, bus (slave)
module mem_port_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int RD_LAT   = 1,
  parameter int MAX_HOLD = 4
) (
  input logic               i_clk,
  input logic               i_rst,
  mem_port_arbiter_if.slave bus
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  typedef enum logic [1:0] {OWN_NONE, OWN_M0, OWN_M1} own_t;
  own_t          r_owner;
  logic          r_last;
  logic [HW-1:0] r_hold;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_dout;
  logic          r_mem_w;
  logic [RD_LAT:0] r_pv, r_pid;
  logic          w_keep0, w_keep1, w_gnt0, w_gnt1, w_gnt, w_sel, w_lock, w_w;
  own_t          w_own_sel;
  assign w_keep0   = r_owner == OWN_M0 && bus.req0 && (!bus.req1 || r_hold < HW'(MAX_HOLD));
  assign w_keep1   = r_owner == OWN_M1 && bus.req1 && (!bus.req0 || r_hold < HW'(MAX_HOLD));
  // r_last=1 means M1 was last, so a tie goes to M0
  assign w_gnt0    = !i_rst && (w_keep0 || (!w_keep1 && bus.req0 && (!bus.req1 || r_last)));
  assign w_gnt1    = !i_rst && !w_gnt0 && bus.req1;
  assign w_gnt     = w_gnt0 || w_gnt1;
  assign w_sel     = w_gnt1;
  assign w_lock    = w_sel ? bus.lock1 : bus.lock0;
  assign w_w       = w_sel ? bus.w1 : bus.w0;
  assign w_own_sel = w_sel ? OWN_M1 : OWN_M0;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_owner    <= OWN_NONE;
      r_last     <= 1'b1;
      r_hold     <= '0;
      r_mem_addr <= '0;
      r_mem_dout <= '0;
      r_mem_w    <= 1'b0;
      r_pv       <= '0;
      r_pid      <= '0;
    end else begin
      r_mem_w <= w_gnt && w_w;
      // stage 0 is aligned with the address register; the last stage lines up with MemDin
      r_pv    <= {r_pv[RD_LAT-1:0], w_gnt && !w_w};
      r_pid   <= {r_pid[RD_LAT-1:0], w_sel};
      if (w_gnt) begin
        r_mem_addr <= w_sel ? bus.addr1 : bus.addr0;
        r_mem_dout <= w_sel ? bus.dout1 : bus.dout0;
        r_last     <= w_sel;
        if (w_lock) begin
          r_owner <= w_own_sel;
          r_hold  <= r_owner != w_own_sel ? HW'(1) : r_hold == HW'(MAX_HOLD) ? r_hold : r_hold + HW'(1);
        end else begin
          r_owner <= OWN_NONE;
          r_hold  <= '0;
        end
      end else begin
        r_owner <= OWN_NONE;
        r_hold  <= '0;
      end
    end
  end
  assign bus.gnt0     = w_gnt0;
  assign bus.gnt1     = w_gnt1;
  assign bus.valid0   = r_pv[RD_LAT] && !r_pid[RD_LAT];
  assign bus.valid1   = r_pv[RD_LAT] && r_pid[RD_LAT];
  assign bus.rd_data  = bus.mem_din;
  assign bus.mem_addr = r_mem_addr;
  assign bus.mem_dout = r_mem_dout;
  assign bus.mem_w    = r_mem_w;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random checks of mem_port_arbiter against a queue-based reference model
module tb_mem_port_arbiter;
  localparam int AW = 16, DW = 16, RD_LAT = 1, MAX_HOLD = 4;
  typedef struct {int due; int id;} rd_t;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus();
  mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_HOLD(MAX_HOLD)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  int n_checks = 0, n_err = 0, cyc = 0;
  int m_owner = -1, m_last = 1, m_hold = 0, m_w = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_dout = '0;
  rd_t q[$];
  int obs_g, obs_v0, obs_v1, obs_w;
  logic [AW-1:0] obs_addr;
  logic [DW-1:0] obs_dout;
  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  function automatic int exp_grant();
    int r[2];
    r[0] = bus.req0;
    r[1] = bus.req1;
    if (rst) return -1;
    if (m_owner >= 0 && r[m_owner] != 0 && (r[1-m_owner] == 0 || m_hold < MAX_HOLD)) return m_owner;
    if (r[0] != 0 && r[1] != 0) return 1 - m_last;
    if (r[0] != 0) return 0;
    if (r[1] != 0) return 1;
    return -1;
  endfunction
  task automatic model_update(input int g);
    int lk, wr;
    if (rst) begin
      m_owner = -1; m_last = 1; m_hold = 0; m_w = 0; m_addr = '0; m_dout = '0;
      q.delete();
    end else if (g < 0) begin
      m_w = 0; m_owner = -1; m_hold = 0;
    end else begin
      lk = g ? int'(bus.lock1) : int'(bus.lock0);
      wr = g ? int'(bus.w1) : int'(bus.w0);
      m_addr = g ? bus.addr1 : bus.addr0;
      m_dout = g ? bus.dout1 : bus.dout0;
      m_w = wr;
      m_last = g;
      if (lk == 0) begin
        m_owner = -1; m_hold = 0;
      end else if (m_owner == g) m_hold = (m_hold + 1 > MAX_HOLD) ? MAX_HOLD : m_hold + 1;
      else begin
        m_owner = g; m_hold = 1;
      end
      if (wr == 0) q.push_back('{due: cyc + 1 + RD_LAT, id: g});
    end
  endtask
  task automatic step();
    int g, vid;
    bus.mem_din = DW'($urandom);
    #1;
    g = exp_grant();
    check("gnt0", bus.gnt0, g == 0);
    check("gnt1", bus.gnt1, g == 1);
    check("mem_addr", bus.mem_addr, m_addr);
    check("mem_dout", bus.mem_dout, m_dout);
    check("mem_w", bus.mem_w, m_w);
    vid = -1;
    if (q.size() > 0 && q[0].due == cyc) begin
      vid = q[0].id;
      void'(q.pop_front());
    end
    check("valid0", bus.valid0, vid == 0);
    check("valid1", bus.valid1, vid == 1);
    check("rd_data", bus.rd_data, bus.mem_din);
    obs_g = bus.gnt1 ? 1 : bus.gnt0 ? 0 : -1;
    obs_v0 = bus.valid0; obs_v1 = bus.valid1; obs_w = bus.mem_w;
    obs_addr = bus.mem_addr; obs_dout = bus.mem_dout;
    @(posedge clk);
    model_update(g);
    cyc++;
    @(negedge clk);
  endtask
  task automatic idle();
    bus.req0 = 0; bus.w0 = 0; bus.lock0 = 0; bus.addr0 = '0; bus.dout0 = '0;
    bus.req1 = 0; bus.w1 = 0; bus.lock1 = 0; bus.addr1 = '0; bus.dout1 = '0;
  endtask
  task automatic do_reset();
    idle();
    rst = 1;
    step();
    rst = 0;
  endtask
  task automatic rand_inputs();
    if (!(bus.req0 && obs_g != 0 && $urandom_range(7) != 0)) begin
      bus.req0 = $urandom_range(3) != 0; bus.w0 = $urandom_range(1); bus.lock0 = $urandom_range(1);
      bus.addr0 = AW'($urandom); bus.dout0 = DW'($urandom);
    end
    if (!(bus.req1 && obs_g != 1 && $urandom_range(7) != 0)) begin
      bus.req1 = $urandom_range(3) != 0; bus.w1 = $urandom_range(1); bus.lock1 = $urandom_range(1);
      bus.addr1 = AW'($urandom); bus.dout1 = DW'($urandom);
    end
    rst = $urandom_range(199) == 0;
  endtask
  initial begin
    int e4[6];
    int e5[5];
    e4 = '{0, 0, 0, 0, 1, 0};
    e5 = '{0, 0, 0, 0, 1};
    idle();
    bus.mem_din = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_addr", bus.mem_addr, 16'h0000);
    check("rst_mem_w", bus.mem_w, 0);
    check("rst_gnt", {bus.gnt0, bus.gnt1, bus.valid0, bus.valid1}, 0);
    rst = 0;
    bus.req0 = 1; bus.addr0 = 16'h0010;
    step();
    check("t1_gnt0", obs_g, 0);
    idle();
    step();
    check("t1_addr", obs_addr, 16'h0010);
    check("t1_w", obs_w, 0);
    for (int i = 0; i < RD_LAT; i++) step();
    check("t1_valid0", {obs_v0[0], obs_v1[0]}, 2'b10);
    do_reset();
    bus.req0 = 1; bus.req1 = 1; bus.addr0 = 16'h0100; bus.addr1 = 16'h0200;
    for (int i = 0; i < 6; i++) begin
      step();
      check("t2_order", obs_g, i % 2);
    end
    idle();
    repeat (RD_LAT + 2) step();
    bus.req1 = 1; bus.w1 = 1; bus.addr1 = 16'h0020; bus.dout1 = 16'hBEEF;
    step();
    check("t3_gnt1", obs_g, 1);
    idle();
    step();
    check("t3_w", obs_w, 1);
    check("t3_addr", obs_addr, 16'h0020);
    check("t3_dout", obs_dout, 16'hBEEF);
    step();
    check("t3_w_drop", obs_w, 0);
    check("t3_no_valid", obs_v1, 0);
    do_reset();
    bus.req0 = 1; bus.lock0 = 1; bus.req1 = 1; bus.lock1 = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("t4_seq", obs_g, e4[i]);
    end
    do_reset();
    bus.req0 = 1; bus.lock0 = 1;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) bus.req1 = 1;
      step();
      check("t5_seq", obs_g, e5[i]);
    end
    idle();
    step();
    bus.req0 = 1; bus.addr0 = 16'h0033;
    step();
    check("t6_gnt0", obs_g, 0);
    idle();
    rst = 1;
    step();
    check("t6_rst_gnt", obs_g, -1);
    rst = 0;
    for (int i = 0; i < RD_LAT + 2; i++) begin
      step();
      check("t6_no_valid", {obs_v0[0], obs_v1[0]}, 2'b00);
      check("t6_addr", obs_addr, 16'h0000);
      check("t6_w", obs_w, 0);
    end
    bus.req0 = 1; bus.req1 = 1;
    step();
    check("t6_tie", obs_g, 0);
    idle();
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      step();
    end
    rst = 0;
    idle();
    repeat (RD_LAT + 2) step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
